// File: rtl/dev_reshuffler_pkg.sv
// Shared types and default geometry for the wide-word reshuffler family.
// The unpacker and the tile slicer both build on these definitions.
package dev_reshuffler_pkg;

  localparam int unsigned DefSpatPar   = 8;
  localparam int unsigned DefDataWidth = 64;
  localparam int unsigned Elems        = DefDataWidth / DefSpatPar;
  localparam int unsigned IdxW         = $clog2(DefSpatPar);

  typedef logic [DefSpatPar-1:0][DefSpatPar-1:0][Elems-1:0] tile_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

endpackage

// File: rtl/dev_tile_slicer.sv
// Combinational selector: picks one row (or one column when transposing) of a
// SpatPar x SpatPar tile and packs it into a single narrow beat.
module dev_tile_slicer
  import dev_reshuffler_pkg::*;
#(
  parameter int unsigned SpatPar   = DefSpatPar,
  parameter int unsigned DataWidth = DefDataWidth
) (
  input  logic [SpatPar*DataWidth-1:0] tile_i,
  input  logic                         transpose_i,
  input  logic [$clog2(SpatPar)-1:0]   idx_i,
  output logic [DataWidth-1:0]         beat_o
);

  localparam int unsigned ElemW = DataWidth / SpatPar;

  // Element j of the beat is tile[idx][j] for rows, tile[j][idx] for columns
  always_comb begin
    int unsigned sel;
    sel    = 32'(idx_i);
    beat_o = '0;
    for (int unsigned j = 0; j < SpatPar; j++) begin
      if (transpose_i) begin
        beat_o[j*ElemW +: ElemW] = tile_i[(j*SpatPar + sel)*ElemW +: ElemW];
      end else begin
        beat_o[j*ElemW +: ElemW] = tile_i[(sel*SpatPar + j)*ElemW +: ElemW];
      end
    end
  end

endmodule

// File: rtl/dev_unpacker.sv
// Serialises one wide tile word into SpatPar narrow beats (rows or columns),
// accepting the next tile on the cycle the last beat drains.
module dev_unpacker
  import dev_reshuffler_pkg::*;
#(
  parameter int unsigned SpatPar   = DefSpatPar,
  parameter int unsigned DataWidth = DefDataWidth
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [SpatPar*DataWidth-1:0] a_i,
  input  logic                         a_valid_i,
  output logic                         a_ready_o,
  input  logic                         csr_en_transpose_i,
  output logic [DataWidth-1:0]         z_o,
  output logic                         z_valid_o,
  input  logic                         z_ready_i,
  output logic                         z_last_o,
  output logic [$clog2(SpatPar)-1:0]   z_idx_o,
  output logic                         busy_o
);

  localparam int unsigned CntW = $clog2(SpatPar);

  state_e                       state_r;
  logic [SpatPar*DataWidth-1:0] buf_r;
  logic [CntW-1:0]              cnt_r;
  logic                         tr_r;

  logic a_success_s;
  logic z_success_s;
  logic last_beat_s;

  assign last_beat_s = (cnt_r == CntW'(SpatPar - 1));
  assign z_valid_o   = (state_r == SEND);
  assign busy_o      = (state_r == SEND);
  assign z_idx_o     = cnt_r;
  assign z_last_o    = (state_r == SEND) & last_beat_s;
  // Reopening on the draining last beat keeps back-to-back tiles bubble-free
  assign a_ready_o   = (state_r == IDLE) | (z_last_o & z_ready_i);
  assign a_success_s = a_valid_i & a_ready_o;
  assign z_success_s = z_valid_o & z_ready_i;

  dev_tile_slicer #(
    .SpatPar  (SpatPar),
    .DataWidth(DataWidth)
  ) u_slicer (
    .tile_i     (buf_r),
    .transpose_i(tr_r),
    .idx_i      (cnt_r),
    .beat_o     (z_o)
  );

  // Tile capture, beat counting and IDLE/SEND sequencing
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= IDLE;
      buf_r   <= '0;
      cnt_r   <= '0;
      tr_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (a_success_s) begin
            buf_r   <= a_i;
            tr_r    <= csr_en_transpose_i;
            cnt_r   <= '0;
            state_r <= SEND;
          end
        end
        SEND: begin
          if (z_success_s) begin
            if (!last_beat_s) begin
              cnt_r <= cnt_r + CntW'(1);
            end else if (a_success_s) begin
              buf_r <= a_i;
              tr_r  <= csr_en_transpose_i;
              cnt_r <= '0;
            end else begin
              cnt_r   <= '0;
              state_r <= IDLE;
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dev_unpacker.sv
// Self-checking bench for dev_unpacker against a beat-queue reference model.
module tb_dev_unpacker;
  import dev_reshuffler_pkg::*;

  localparam int SP = 8;
  localparam int DW = 64;
  localparam int E  = DW / SP;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic [SP*DW-1:0]  a_i;
  logic              a_valid_i;
  logic              a_ready_o;
  logic              csr_en_transpose_i;
  logic [DW-1:0]     z_o;
  logic              z_valid_o;
  logic              z_ready_i;
  logic              z_last_o;
  logic [2:0]        z_idx_o;
  logic              busy_o;

  always #5 clk_i = ~clk_i;

  dev_unpacker #(.SpatPar(SP), .DataWidth(DW)) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .a_i               (a_i),
    .a_valid_i         (a_valid_i),
    .a_ready_o         (a_ready_o),
    .csr_en_transpose_i(csr_en_transpose_i),
    .z_o               (z_o),
    .z_valid_o         (z_valid_o),
    .z_ready_i         (z_ready_i),
    .z_last_o          (z_last_o),
    .z_idx_o           (z_idx_o),
    .busy_o            (busy_o)
  );

  typedef struct {
    logic [DW-1:0] data;
    int            idx;
    bit            last;
  } beat_t;

  beat_t         q[$];
  logic [DW-1:0] obs[$];
  int            checks   = 0;
  int            failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Expected beats of a tile: rows of the element matrix, or its columns
  function automatic void push_tile(input tile_t t, input bit tr);
    for (int k = 0; k < SP; k++) begin
      beat_t b;
      b.data = '0;
      for (int j = 0; j < SP; j++) b.data[j*E +: E] = tr ? t[j][k] : t[k][j];
      b.idx  = k;
      b.last = (k == SP - 1);
      q.push_back(b);
    end
  endfunction

  function automatic logic [SP*DW-1:0] pattern_tile();
    logic [SP*DW-1:0] v;
    for (int k = 0; k < SP*SP; k++) v[k*8 +: 8] = 8'(k);
    return v;
  endfunction

  function automatic logic [SP*DW-1:0] rnd_tile();
    logic [SP*DW-1:0] v;
    for (int w = 0; w < SP*DW/32; w++) v[w*32 +: 32] = $urandom;
    return v;
  endfunction

  // Streams ntiles through the DUT, comparing every cycle against the model
  task automatic run(input int ntiles, input int tr_mask, input bit rand_data, input bit b2b,
                     input int stall_at, input int stall_len, input bit rand_rdy);
    int               accepted = 0;
    int               stalled  = 0;
    int               cyc      = 0;
    logic [SP*DW-1:0] cur      = '0;
    bit               cur_tr   = 1'b0;
    bit               last_tr  = 1'b0;
    bit               have_cur = 1'b0;
    bit               exp_valid;
    bit               exp_ready;
    obs.delete();
    forever begin
      if (!have_cur && accepted < ntiles) begin
        cur      = rand_data ? rnd_tile() : pattern_tile();
        cur_tr   = tr_mask[accepted];
        have_cur = 1'b1;
      end
      if (have_cur && (b2b || q.size() == 0)) begin
        a_valid_i          = 1'b1;
        a_i                = cur;
        csr_en_transpose_i = cur_tr;
      end else begin
        a_valid_i          = 1'b0;
        a_i                = rnd_tile();
        csr_en_transpose_i = ~last_tr;
      end
      if (stall_at >= 0 && obs.size() == stall_at && stalled < stall_len) begin
        z_ready_i = 1'b0;
        stalled++;
      end else begin
        z_ready_i = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      @(negedge clk_i);
      exp_valid = (q.size() != 0);
      exp_ready = !exp_valid || (q[0].last && z_ready_i);
      chk("z_valid", z_valid_o, exp_valid);
      chk("busy", busy_o, exp_valid);
      chk("a_ready", a_ready_o, exp_ready);
      if (exp_valid) begin
        chk("z_data", z_o, q[0].data);
        chk("z_idx", z_idx_o, q[0].idx);
        chk("z_last", z_last_o, q[0].last);
        if (z_ready_i) obs.push_back(z_o);
      end else begin
        chk("z_last_idle", z_last_o, 1'b0);
      end
      @(posedge clk_i);
      if (exp_valid && z_ready_i) void'(q.pop_front());
      if (a_valid_i && exp_ready) begin
        push_tile(cur, cur_tr);
        last_tr  = cur_tr;
        accepted++;
        have_cur = 1'b0;
      end
      #1;
      cyc++;
      if (accepted == ntiles && q.size() == 0) break;
      if (cyc > 3000) begin
        checks++;
        failures++;
        $error("FAIL timeout: observed=%0d accepted expected=%0d", accepted, ntiles);
        break;
      end
    end
    a_valid_i = 1'b0;
    z_ready_i = 1'b1;
  endtask

  task automatic chk_obs(input string tag, input int n, input logic [63:0] exp);
    if (obs.size() > n) chk(tag, obs[n], exp);
    else chk({tag, "_missing"}, 64'(obs.size()), 64'(n + 1));
  endtask

  initial begin
    rst_ni             = 1'b0;
    a_i                = '0;
    a_valid_i          = 1'b0;
    csr_en_transpose_i = 1'b0;
    z_ready_i          = 1'b1;
    #12;
    chk("rst_z_valid", z_valid_o, 1'b0);
    chk("rst_z_last", z_last_o, 1'b0);
    chk("rst_z_idx", z_idx_o, 3'd0);
    chk("rst_z_o", z_o, 64'h0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_a_ready", a_ready_o, 1'b1);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // Rows, then columns, of the 0..63 byte pattern
    run(1, 0, 1'b0, 1'b0, -1, 0, 1'b0);
    chk_obs("row_beat0", 0, 64'h0706050403020100);
    chk_obs("row_beat7", 7, 64'h3F3E3D3C3B3A3938);
    run(1, 1, 1'b0, 1'b0, -1, 0, 1'b0);
    chk_obs("col_beat0", 0, 64'h3830282018100800);
    chk_obs("col_beat7", 7, 64'h3F372F271F170F07);

    // Back-to-back tiles, then a 5-cycle stall at beat 3
    run(2, 0, 1'b0, 1'b1, -1, 0, 1'b0);
    chk("b2b_count", 64'(obs.size()), 64'd16);
    chk_obs("b2b_beat8", 8, 64'h0706050403020100);
    run(1, 0, 1'b0, 1'b0, 3, 5, 1'b0);
    chk_obs("stall_beat3", 3, 64'h1F1E1D1C1B1A1918);

    // Transpose input flips while a row tile drains; next tile uses columns
    run(2, 2, 1'b0, 1'b0, -1, 0, 1'b0);
    chk_obs("tog_row0", 0, 64'h0706050403020100);
    chk_obs("tog_row2", 2, 64'h1716151413121110);
    chk_obs("tog_col0", 8, 64'h3830282018100800);

    // Reset asserted while beat 4 is on the output
    a_valid_i          = 1'b1;
    a_i                = pattern_tile();
    csr_en_transpose_i = 1'b0;
    z_ready_i          = 1'b1;
    @(posedge clk_i);
    #1 a_valid_i = 1'b0;
    repeat (4) @(posedge clk_i);
    #2;
    chk("pre_rst_idx", z_idx_o, 3'd4);
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_z_valid", z_valid_o, 1'b0);
    chk("mid_rst_a_ready", a_ready_o, 1'b1);
    chk("mid_rst_z_idx", z_idx_o, 3'd0);
    chk("mid_rst_busy", busy_o, 1'b0);
    chk("mid_rst_z_o", z_o, 64'h0);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    q.delete();
    run(1, 0, 1'b0, 1'b0, -1, 0, 1'b0);
    chk_obs("post_rst_beat0", 0, 64'h0706050403020100);
    chk("post_rst_count", 64'(obs.size()), 64'd8);

    // Randomised traffic: data, transpose, offer style and ready pattern
    for (int r = 0; r < 4; r++) begin
      run(12, int'($urandom), 1'b1, 1'($urandom_range(0, 1)),
          int'($urandom_range(0, 7)), int'($urandom_range(0, 6)), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dev_unpacker.md
Name: dev_unpacker

Overview:
- Receive-side counterpart of the team's wide-word reshuffler.
- Accepts one wide tile word of SpatPar x SpatPar elements over a valid/ready port and serialises it into SpatPar narrow beats of DataWidth bits on a second valid/ready port.
- Each beat is either a row of the tile or, with transpose enabled, a column of the tile.
- Sits between a wide-output accelerator datapath and a narrow streamer or TCDM write port.

Parameters:
- SpatPar, 8, tile edge length and beats per tile; power of two, >=2.
- DataWidth, 64, narrow beat width in bits; must be divisible by SpatPar.
- Elems, DataWidth/SpatPar, element width in bits (derived; do not override).
- IdxW, $clog2(SpatPar), beat-index width (derived).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- a_i  in  SpatPar*DataWidth  wide tile word; element [i][j] at bits (i*SpatPar+j)*Elems +: Elems.
- a_valid_i  in  1  tile word valid.
- a_ready_o  out  1  tile word ready.
- csr_en_transpose_i  in  1  1 = emit columns, 0 = emit rows; sampled only on tile accept.
- z_o  out  DataWidth  current narrow beat.
- z_valid_o  out  1  beat valid.
- z_ready_i  in  1  beat ready.
- z_last_o  out  1  high with the final beat (index SpatPar-1) of a tile.
- z_idx_o  out  IdxW  index of the current beat within the tile.
- busy_o  out  1  high while a tile is held (state SEND).

Behaviour:
- Handshakes:
  - a_success = a_valid_i & a_ready_o.
  - z_success = z_valid_o & z_ready_i.
  - Standard AXI-style rules: z_valid_o, once high, is never dropped and z_o never changes until z_success.
- State, reset values and outputs:
  - Registers: state {IDLE, SEND}, tile buffer buf_q (SpatPar*DataWidth), beat counter cnt_q (IdxW), transpose latch tr_q.
  - Reset: state=IDLE, buf_q=0, cnt_q=0, tr_q=0.
  - Outputs at reset: z_valid_o=0, z_last_o=0, z_idx_o=0, z_o=0, busy_o=0, a_ready_o=1.
  - z_valid_o = busy_o = (state==SEND).
  - z_idx_o = cnt_q.
  - z_last_o = (state==SEND) & (cnt_q==SpatPar-1).
- Beat formation, combinational from buf_q, tr_q and cnt_q:
  - tr_q=0: z_o element j = buf_q element [cnt_q][j], i.e. beat = buf_q[cnt_q*DataWidth +: DataWidth].
  - tr_q=1: z_o element j = buf_q element [j][cnt_q].
  - In both cases element j occupies z_o[j*Elems +: Elems].
- a_ready_o = (state==IDLE) | (z_last_o & z_ready_i). This accepts the next tile on the same cycle the last beat drains: no bubble.
- IDLE:
  - On a_success: buf_q<=a_i, tr_q<=csr_en_transpose_i, cnt_q<=0, go to SEND.
  - Latency: accept at cycle t, beat 0 valid at t+1.
- SEND, on z_success:
  - If cnt_q<SpatPar-1: cnt_q<=cnt_q+1.
  - If cnt_q==SpatPar-1 and a_success in the same cycle: load the new tile as in IDLE and stay in SEND.
  - If cnt_q==SpatPar-1 and no a_success: cnt_q<=0, go to IDLE.
- SEND without z_success: all registers hold. A stall of any length is allowed.
- csr_en_transpose_i changes during SEND are ignored; they take effect on the next tile accept only.
- Throughput: one tile per SpatPar cycles with z_ready_i held high, back-to-back.
- Reset asserted mid-tile: the tile is discarded and all state returns to the reset values immediately; no partial beats follow after reset release.
- buf_q is written only on a_success; no other path writes it.

Decomposition:
- Package dev_reshuffler_pkg holds:
  - derived constants Elems and IdxW;
  - typedef tile_t = logic [SpatPar-1:0][SpatPar-1:0][Elems-1:0];
  - state enum {IDLE, SEND}.
- One natural sub-module, dev_tile_slicer: purely combinational. It takes tile, transpose and index and returns the DataWidth beat. The reshuffler's transpose mapping can reuse it.
- dev_unpacker holds the FSM, counter and buffer.

Test Plan (SpatPar=8, DataWidth=64, Elems=8; input byte k = k for k=0..63):
1. Row mode: transpose=0, z_ready=1. Required beats: beat0 = 0x0706050403020100, beat7 = 0x3F3E3D3C3B3A3938. z_last_o high only on beat7; z_idx_o runs 0..7; beat0 arrives 1 cycle after accept.
2. Column mode: transpose=1. Required beats: beat0 = 0x3830282018100800, beat7 = 0x3F372F271F170F07.
3. Back-to-back: two tiles offered continuously with z_ready=1. Required: 16 consecutive valid beats with no bubble; a_ready_o high exactly on the accept cycle and on the beat7 cycle.
4. Backpressure: z_ready=0 for 5 cycles at beat3. Required: z_o, z_idx_o=3 and z_valid_o=1 stable throughout; a_ready_o=0; transmission resumes with beat3.
5. Transpose toggled mid-tile: set transpose 0 at accept, 1 at beat2. Required: the whole tile is emitted as rows; the next tile accepted with transpose=1 is emitted as columns.
6. Reset mid-tile: assert rst_ni low at beat4. Required: z_valid_o=0, a_ready_o=1 and z_idx_o=0 immediately. A new tile sent after reset release starts at beat0 with correct data.
